mac_accumulator: RTL and testbench

- Downstream consumer of the input/weight byte selector. It drives the selector's `inc` strobe for N consecutive cycles and multiplies each returned input/weight byte pair.
- It accumulates the N signed products into a wide sum and presents the neuron result once.
- Output is given both full-width and as an optionally ReLU'd, 8-bit saturated value for the next layer.

---
 rtl/nn_pkg.sv | 25 ++
 rtl/mac_accumulator_mul_stage.sv | 25 ++
 rtl/mac_accumulator.sv | 96 +++++++++
 tb/tb_mac_accumulator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron datapath: byte/product widths,
// the dot-product controller states and the 8-bit clamp used between layers.
package nn_pkg;

  localparam int DATA_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Callers sign-extend their wide value to 32 bits before clamping.
  function automatic logic signed [DATA_W-1:0] sat8(input logic signed [31:0] v);
    if (v > 32'sd127)
      return 8'h7F;
    else if (v < -32'sd128)
      return 8'h80;
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/mac_accumulator_mul_stage.sv
// Registered signed 8x8 multiply; the valid bit travels with the product.
module mul_stage
  import nn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [PROD_W-1:0] prod,
  output logic                     prod_valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      prod       <= '0;
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= valid;
      if (valid)
        prod <= a * b;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product engine: strobes the byte selector n times, multiplies each
// returned pair and accumulates the signed products into one neuron result.
//
//   state | meaning
//   IDLE  | waiting for start; result/result_sat hold the last answer
//   ISSUE | inc high, one selector pair requested per cycle
//   DRAIN | inc low, multiply/accumulate pipeline emptying
//   DONE  | done pulse, result/result_sat valid
module mac_accumulator
  import nn_pkg::*;
#(
  parameter int n    = 2,
  parameter bit RELU = 1'b1,
  localparam int ACC_W = PROD_W + $clog2(n) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  output logic                     inc,
  output logic                     busy,
  output logic                     done,
  output logic signed [ACC_W-1:0]  result,
  output logic signed [DATA_W-1:0] result_sat
);

  localparam int CNT_W = (n > 1) ? $clog2(n) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(n - 1);

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic                      v1;
  logic                      v2;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   relu_val;

  assign inc  = (state == ISSUE);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  mul_stage u_mul (
    .clk        (clk),
    .rst        (rst),
    .valid      (v1),
    .a          (in_a),
    .b          (in_b),
    .prod       (prod),
    .prod_valid (v2)
  );

  assign acc_next = v2 ? (acc + ACC_W'(prod)) : acc;
  assign relu_val = (RELU && acc_next[ACC_W-1]) ? '0 : acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      v1         <= 1'b0;
      acc        <= '0;
      result     <= '0;
      result_sat <= '0;
    end else begin
      v1  <= inc;
      acc <= acc_next;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            cnt   <= '0;
            acc   <= '0;
          end
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= DRAIN;
        end
        DRAIN: begin
          // Once v1 is low the last product sits in v2 and is folded in on
          // this edge, so the pipeline is empty when DONE is entered.
          if (!v1) begin
            state      <= DONE;
            result     <= acc_next;
            result_sat <= sat8(32'(relu_val));
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench: four accumulators (n=2 ReLU/no-ReLU, n=4, n=1) fed by
// a behavioural byte-selector model, checked against plain integer dot products.
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_ab = 1'b0, start_c = 1'b0, start_d = 1'b0;
  logic signed [7:0] in_a = '0, in_b = '0;

  logic inc_a, busy_a, done_a, inc_b, busy_b, done_b;
  logic inc_c, busy_c, done_c, inc_d, busy_d, done_d;
  logic signed [17:0] res_a, res_b;
  logic signed [18:0] res_c;
  logic signed [16:0] res_d;
  logic signed [7:0]  sat_a, sat_b, sat_c, sat_d;

  always #5 clk = ~clk;

  mac_accumulator #(.n(2), .RELU(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_ab), .in_a(in_a), .in_b(in_b),
    .inc(inc_a), .busy(busy_a), .done(done_a), .result(res_a), .result_sat(sat_a));
  mac_accumulator #(.n(2), .RELU(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_ab), .in_a(in_a), .in_b(in_b),
    .inc(inc_b), .busy(busy_b), .done(done_b), .result(res_b), .result_sat(sat_b));
  mac_accumulator #(.n(4), .RELU(1'b1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .in_a(in_a), .in_b(in_b),
    .inc(inc_c), .busy(busy_c), .done(done_c), .result(res_c), .result_sat(sat_c));
  mac_accumulator #(.n(1), .RELU(1'b1)) dut_d (
    .clk(clk), .rst(rst), .start(start_d), .in_a(in_a), .in_b(in_b),
    .inc(inc_d), .busy(busy_d), .done(done_d), .result(res_d), .result_sat(sat_d));

  // group 0 = dut_a/dut_b, 1 = dut_c, 2 = dut_d
  int grp = 0;
  logic signed [7:0] pa [4];
  logic signed [7:0] pb [4];
  int sidx = 0;

  logic cur_inc, cur_busy, cur_done;
  int   cur_res, cur_sat;

  always_comb begin
    cur_inc  = inc_a;
    cur_busy = busy_a;
    cur_done = done_a;
    cur_res  = int'(res_a);
    cur_sat  = int'(sat_a);
    if (grp == 1) begin
      cur_inc = inc_c; cur_busy = busy_c; cur_done = done_c;
      cur_res = int'(res_c); cur_sat = int'(sat_c);
    end else if (grp == 2) begin
      cur_inc = inc_d; cur_busy = busy_d; cur_done = done_d;
      cur_res = int'(res_d); cur_sat = int'(sat_d);
    end
  end

  // Selector model: registers the next pair on every edge where inc is high.
  always @(posedge clk) begin
    if (cur_inc) begin
      in_a <= pa[sidx];
      in_b <= pb[sidx];
      sidx <= sidx + 1;
    end else begin
      sidx <= 0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_sat(input int v, input bit relu);
    int x;
    x = (relu && v < 0) ? 0 : v;
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic int ref_dot(input int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s += int'(pa[i]) * int'(pb[i]);
    return s;
  endfunction

  task automatic set_start(input int g, input logic v);
    case (g)
      0:       start_ab = v;
      1:       start_c  = v;
      default: start_d  = v;
    endcase
  endtask

  task automatic set_pairs(input int a0, b0, a1, b1, a2, b2, a3, b3);
    pa[0] = 8'(a0); pb[0] = 8'(b0); pa[1] = 8'(a1); pb[1] = 8'(b1);
    pa[2] = 8'(a2); pb[2] = 8'(b2); pa[3] = 8'(a3); pb[3] = 8'(b3);
  endtask

  // One full run; optionally pulse start during DONE to show it is ignored.
  task automatic run_dot(input int g, input int k, input bit poke_done);
    int sum;
    grp = g;
    sum = ref_dot(k);
    @(negedge clk);
    set_start(g, 1'b1);
    @(posedge clk);
    #1 set_start(g, 1'b0);
    for (int c = 1; c <= k + 3; c++) begin
      @(negedge clk);
      check($sformatf("inc g%0d c%0d", g, c), int'(cur_inc), int'(c <= k));
      check($sformatf("busy g%0d c%0d", g, c), int'(cur_busy), 1);
      check($sformatf("done g%0d c%0d", g, c), int'(cur_done), int'(c == k + 3));
      if (c == k + 3) begin
        check($sformatf("result g%0d", g), cur_res, sum);
        check($sformatf("result_sat g%0d", g), cur_sat, ref_sat(sum, g != 0 || 1'b1));
        if (g == 0) begin
          check("result norelu", int'(res_b), sum);
          check("result_sat norelu", int'(sat_b), ref_sat(sum, 1'b0));
        end
        if (poke_done) set_start(g, 1'b1);
      end
    end
    @(negedge clk);
    set_start(g, 1'b0);
    check($sformatf("idle busy g%0d", g), int'(cur_busy), 0);
    @(negedge clk);
    check($sformatf("no rerun busy g%0d", g), int'(cur_busy), 0);
    check($sformatf("held result g%0d", g), cur_res, sum);
  endtask

  initial begin
    int ndone, ninc, first_done, second_done, sum;

    repeat (3) @(negedge clk);
    check("reset inc", int'(inc_a), 0);
    check("reset busy", int'(busy_a), 0);
    check("reset done", int'(done_a), 0);
    check("reset result", int'(res_a), 0);
    check("reset result_sat", int'(sat_a), 0);
    check("reset busy c", int'(busy_c), 0);
    rst = 1'b0;

    set_pairs(3, 5, 4, 6, 0, 0, 0, 0);           run_dot(0, 2, 1'b0);
    set_pairs(-10, 10, 2, 3, 0, 0, 0, 0);        run_dot(0, 2, 1'b0);
    set_pairs(100, 100, 100, 100, 0, 0, 0, 0);   run_dot(0, 2, 1'b0);
    set_pairs(-128, 127, -128, 127, 0, 0, 0, 0); run_dot(0, 2, 1'b1);

    // Reset in the cycle after the first inc aborts the run.
    grp = 0;
    set_pairs(7, 7, 9, 9, 0, 0, 0, 0);
    @(negedge clk); start_ab = 1'b1;
    @(posedge clk); #1 start_ab = 1'b0;
    @(negedge clk);
    check("abort first inc", int'(inc_a), 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort inc", int'(inc_a), 0);
    check("abort busy", int'(busy_a), 0);
    check("abort result", int'(res_a), 0);
    check("abort result_sat", int'(sat_a), 0);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ndone += int'(done_a);
    end
    check("abort no done", ndone, 0);
    set_pairs(1, 1, 2, 2, 0, 0, 0, 0); run_dot(0, 2, 1'b0);

    // start held high: one burst of n incs per run, done every n+4 cycles.
    grp = 0;
    set_pairs(-3, 11, 25, -2, 0, 0, 0, 0);
    sum = ref_dot(2);
    @(negedge clk); start_ab = 1'b1;
    ndone = 0; ninc = 0; first_done = -1; second_done = -1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      ninc += int'(inc_a);
      if (done_a) begin
        ndone++;
        if (first_done < 0) first_done = c; else second_done = c;
        check("held result", int'(res_a), sum);
      end
    end
    start_ab = 1'b0;
    check("held inc count", ninc, 4);
    check("held done count", ndone, 2);
    check("held first done", first_done, 5);
    check("held second done", second_done, 11);
    repeat (8) @(negedge clk);

    set_pairs(-128, -128, -128, -128, -128, -128, -128, -128); run_dot(1, 4, 1'b0);
    set_pairs(-7, 9, 0, 0, 0, 0, 0, 0);                        run_dot(2, 1, 1'b0);
    set_pairs(127, 127, 0, 0, 0, 0, 0, 0);                     run_dot(2, 1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) begin
        pa[i] = 8'($urandom);
        pb[i] = 8'($urandom);
      end
      case (r % 3)
        0:       run_dot(0, 2, 1'b0);
        1:       run_dot(1, 4, 1'b0);
        default: run_dot(2, 1, 1'b0);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
